// File: rtl/path_follower_if.sv
// Planner-to-follower command channel: valid/ready handshake carrying a 2-bit move code and an end-of-path marker.
interface path_follower_if;
    logic       cmd_valid;
    logic [1:0] cmd_data;
    logic       cmd_last;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_data, output cmd_last, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_data, input cmd_last, output cmd_ready);
endinterface

// File: rtl/path_follower.sv
// Path follower: queues planner moves, issues one per node (motor_go 1 cycle after node_detect); cmd_ready drops when full.
// Optional PATH_FOLLOWER_WATCHDOG_EN aborts a turn that lasts TIMEOUT cycles (err set, queue flushed, back to IDLE).
module path_follower #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 50_000_000
) (
    input  logic            clk_50,
    input  logic            reset,
    path_follower_if.slave  cmd,
    input  logic            node_detect,
    input  logic            turn_done,
    output logic [1:0]      motor_cmd,
    output logic            motor_go,
    output logic [1:0]      heading,
    output logic [7:0]      nodes_passed,
    output logic            busy,
    output logic            path_done,
    output logic            err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [1:0]  CMD_STRAIGHT = 2'b00;

    typedef enum logic [2:0] {S_IDLE, S_WAIT_NODE, S_ISSUE, S_TURNING, S_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic        r_rdy_en;
    logic        w_empty, w_full, w_push, w_pop, w_flush;
    logic [2:0]  w_head;
    logic [1:0]  r_cur_cmd;
    logic        r_cur_last;
    logic [1:0]  r_motor_cmd, w_motor_cmd_nxt, r_heading, w_heading_nxt;
    logic [7:0]  r_nodes, w_nodes_nxt;
    logic        r_motor_go, w_motor_go_nxt, r_busy, w_busy_nxt;
    logic        r_path_done, w_path_done_nxt, r_err, w_err_nxt;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign w_pop   = (r_state == S_WAIT_NODE) && node_detect && !w_empty;
    // A pop frees the head slot this cycle, so a full queue can still take a push alongside it.
    assign cmd.cmd_ready = r_rdy_en && (!w_full || w_pop);
    assign w_push  = cmd.cmd_valid && cmd.cmd_ready;

    always_ff @(posedge clk_50) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {cmd.cmd_last, cmd.cmd_data};
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_flush)    r_rd_ptr <= w_push ? r_wr_ptr + PTR_ONE : r_wr_ptr;
            else if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    function automatic logic [1:0] f_turn(input logic [1:0] h, input logic [1:0] c);
        logic [1:0] r;
        r = h;
        case (c)
            2'b01: case (h)  // left
                2'b10:   r = 2'b00;
                2'b00:   r = 2'b11;
                2'b11:   r = 2'b01;
                default: r = 2'b10;
            endcase
            2'b10: case (h)  // right
                2'b10:   r = 2'b01;
                2'b01:   r = 2'b11;
                2'b11:   r = 2'b00;
                default: r = 2'b10;
            endcase
            2'b11:   r = h ^ 2'b01;
            default: r = h;
        endcase
        return r;
    endfunction

`ifdef PATH_FOLLOWER_WATCHDOG_EN
    logic [31:0] r_wd_cnt;
    logic        w_wd_exp;
    assign w_wd_exp = (r_wd_cnt == 32'(TIMEOUT - 1));

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset)                    r_wd_cnt <= '0;
        else if (r_state == S_TURNING) r_wd_cnt <= r_wd_cnt + 32'd1;
        else                          r_wd_cnt <= '0;
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |32'(TIMEOUT);
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_motor_go_nxt  = 1'b0;
        w_motor_cmd_nxt = r_motor_cmd;
        w_heading_nxt   = r_heading;
        w_nodes_nxt     = r_nodes;
        w_path_done_nxt = 1'b0;
        w_err_nxt       = r_err;
        w_flush         = 1'b0;
        case (r_state)
            S_IDLE: if (!w_empty) begin
                w_state_nxt = S_WAIT_NODE;
                w_nodes_nxt = 8'd0;
            end
            S_WAIT_NODE: if (node_detect) begin
                if (!w_empty) begin
                    w_state_nxt     = S_ISSUE;
                    w_motor_go_nxt  = 1'b1;
                    w_motor_cmd_nxt = w_head[1:0];
                end else begin
                    w_err_nxt = 1'b1;
                end
            end
            S_ISSUE: begin
                w_nodes_nxt   = (r_nodes == 8'hFF) ? r_nodes : r_nodes + 8'd1;
                w_heading_nxt = f_turn(r_heading, r_cur_cmd);
                if (r_cur_cmd != CMD_STRAIGHT) begin
                    w_state_nxt = S_TURNING;
                end else if (r_cur_last) begin
                    w_state_nxt     = S_DONE;
                    w_path_done_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_WAIT_NODE;
                end
            end
            S_TURNING: begin
                if (turn_done) begin
                    w_state_nxt     = r_cur_last ? S_DONE : S_WAIT_NODE;
                    w_path_done_nxt = r_cur_last;
                end
`ifdef PATH_FOLLOWER_WATCHDOG_EN
                else if (w_wd_exp) begin
                    w_err_nxt   = 1'b1;
                    w_flush     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
`endif
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_motor_cmd <= 2'b00;
            r_motor_go  <= 1'b0;
            r_heading   <= 2'b00;
            r_nodes     <= 8'd0;
            r_busy      <= 1'b0;
            r_path_done <= 1'b0;
            r_err       <= 1'b0;
            r_cur_cmd   <= 2'b00;
            r_cur_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_motor_cmd <= w_motor_cmd_nxt;
            r_motor_go  <= w_motor_go_nxt;
            r_heading   <= w_heading_nxt;
            r_nodes     <= w_nodes_nxt;
            r_busy      <= w_busy_nxt;
            r_path_done <= w_path_done_nxt;
            r_err       <= w_err_nxt;
            if (w_pop) {r_cur_last, r_cur_cmd} <= w_head;
        end
    end

    assign motor_cmd    = r_motor_cmd;
    assign motor_go     = r_motor_go;
    assign heading      = r_heading;
    assign nodes_passed = r_nodes;
    assign busy         = r_busy;
    assign path_done    = r_path_done;
    assign err          = r_err;
endmodule

// File: tb/tb_path_follower.sv
// Randomised path-follower bench against a queue/angle reference model.
module tb_path_follower;
    localparam int DEPTH = 4;
    localparam int TMO   = 20;

    logic       clk_50 = 1'b0;
    logic       reset = 1'b1;
    logic       node_detect = 1'b0;
    logic       turn_done = 1'b0;
    logic [1:0] motor_cmd, heading;
    logic       motor_go, busy, path_done, err;
    logic [7:0] nodes_passed;

    path_follower_if cmd_if ();

    path_follower #(.DEPTH(DEPTH), .TIMEOUT(TMO)) u_dut (
        .clk_50(clk_50), .reset(reset), .cmd(cmd_if),
        .node_detect(node_detect), .turn_done(turn_done),
        .motor_cmd(motor_cmd), .motor_go(motor_go), .heading(heading),
        .nodes_passed(nodes_passed), .busy(busy), .path_done(path_done), .err(err)
    );

    always #5 clk_50 = ~clk_50;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: queued commands, heading as an angle (E=0, N=90, W=180, S=270)
    bit [2:0] mq[$];
    bit [2:0] pq[$];
    int  hdeg = 180;
    int  np_exp = 0;
    bit  in_path = 1'b0;
    bit  err_exp = 1'b0;
    int  n_go_exp = 0, n_go_seen = 0;
    int  n_pd_exp = 0, n_pd_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] deg2code(input int d);
        case (d)
            0:       return 2'b01;
            90:      return 2'b10;
            180:     return 2'b00;
            default: return 2'b11;
        endcase
    endfunction

    function automatic int rotate(input int d, input logic [1:0] c);
        case (c)
            2'b01:   return (d + 90) % 360;
            2'b10:   return (d + 270) % 360;
            2'b11:   return (d + 180) % 360;
            default: return d;
        endcase
    endfunction

    always @(negedge clk_50) begin
        if (!reset) begin
            if (motor_go)  n_go_seen++;
            if (path_done) n_pd_seen++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout");
        $fatal(1, "simulation time limit reached");
    end

    task automatic step();
        @(posedge clk_50);
        #1;
    endtask

    task automatic check_rst(input string tag);
        check({tag, "_rdy"},  cmd_if.cmd_ready, 0);
        check({tag, "_mcmd"}, motor_cmd, 0);
        check({tag, "_go"},   motor_go, 0);
        check({tag, "_hdg"},  heading, 0);
        check({tag, "_np"},   nodes_passed, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pd"},   path_done, 0);
        check({tag, "_err"},  err, 0);
    endtask

    task automatic model_reset();
        mq.delete();
        hdeg = 180; np_exp = 0; in_path = 1'b0; err_exp = 1'b0;
    endtask

    task automatic push_cmd(input bit [2:0] pv, output bit acc);
        bit exp_rdy;
        exp_rdy = (mq.size() < DEPTH);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_data  = pv[1:0];
        cmd_if.cmd_last  = pv[2];
        @(negedge clk_50);
        acc = cmd_if.cmd_ready;
        check("push_rdy", acc, exp_rdy);
        @(posedge clk_50);
        #1;
        cmd_if.cmd_valid = 1'b0;
        if (exp_rdy) mq.push_back(pv);
    endtask

    task automatic node_step(input bit with_push, input bit [2:0] pv, input bit do_turn, input bit spur);
        bit exp_go, exp_acc;
        bit [2:0] e;
        int k;
        e = 3'b000;
        node_detect = 1'b1;
        if (with_push) begin
            cmd_if.cmd_valid = 1'b1;
            cmd_if.cmd_data  = pv[1:0];
            cmd_if.cmd_last  = pv[2];
        end
        @(negedge clk_50);
        check("go_early", motor_go, 0);
        exp_go  = (mq.size() > 0);
        exp_acc = with_push && (mq.size() < DEPTH || exp_go);
        if (with_push) check("rdy_pop", cmd_if.cmd_ready, exp_acc);
        @(posedge clk_50);
        #1;
        node_detect = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        if (exp_go) e = mq.pop_front();
        if (exp_acc) mq.push_back(pv);
        @(negedge clk_50);
        check("go", motor_go, exp_go);
        check("rdy_after", cmd_if.cmd_ready, mq.size() < DEPTH);
        if (!exp_go) begin
            err_exp = 1'b1;
            check("err_empty", err, 1);
            check("busy_wait", busy, 1);
            step();
        end else begin
            check("mcmd", motor_cmd, e[1:0]);
            n_go_exp++;
            if (!in_path) np_exp = 0;
            in_path = 1'b1;
            if (np_exp < 255) np_exp++;
            hdeg = rotate(hdeg, e[1:0]);
            step();
            check("hdg", heading, deg2code(hdeg));
            check("np", nodes_passed, np_exp);
            check("mcmd_hold", motor_cmd, e[1:0]);
            check("go_1cyc", motor_go, 0);
            check("err", err, err_exp);
            if (e[1:0] != 2'b00) begin
                check("busy_turn", busy, 1);
                if (do_turn) begin
                    k = $urandom_range(0, 3);
                    repeat (k) step();
                    if (spur) begin
                        node_detect = 1'b1;
                        step();
                        node_detect = 1'b0;
                        check("spur_node", motor_go, 0);
                    end
                    turn_done = 1'b1;
                    step();
                    turn_done = 1'b0;
                end
            end
            if (do_turn || e[1:0] == 2'b00) begin
                if (e[2]) begin
                    check("pdone", path_done, 1);
                    check("busy_done", busy, 1);
                    n_pd_exp++;
                    in_path = 1'b0;
                    step();
                    check("pdone_1cyc", path_done, 0);
                    check("busy_idle", busy, 0);
                end else begin
                    check("pdone0", path_done, 0);
                end
            end
        end
    endtask

    task automatic run_path();
        bit acc;
        foreach (pq[i]) push_cmd(pq[i], acc);
        step();
        step();
        foreach (pq[i]) begin
            if ($urandom_range(0, 3) == 0) begin
                turn_done = 1'b1;
                step();
                turn_done = 1'b0;
            end
            node_step(1'b0, 3'b000, 1'b1, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        bit acc;
        int len;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_data  = 2'b00;
        cmd_if.cmd_last  = 1'b0;
        step();
        step();
        check_rst("rst");
        reset = 1'b0;
        check("rdy_pre_clk", cmd_if.cmd_ready, 0);
        step();
        check("rdy_post_clk", cmd_if.cmd_ready, 1);
        model_reset();

        // left, right, straight(last): W -> S -> W -> W
        pq.delete(); pq.push_back(3'b001); pq.push_back(3'b010); pq.push_back(3'b100);
        run_path();
        check("t036_hdg", heading, 2'b00);
        check("t036_np", nodes_passed, 3);

        // single backward: W -> E
        pq.delete(); pq.push_back(3'b111);
        run_path();
        check("t037_hdg", heading, 2'b01);
        check("t037_np", nodes_passed, 1);

        // fill, overflow, then push alongside a pop while full
        for (int i = 0; i < DEPTH; i++) push_cmd(3'b000, acc);
        push_cmd(3'b100, acc);
        check("t038_drop", acc, 0);
        step();
        node_step(1'b1, 3'b100, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            step();
            node_step(1'b0, 3'b000, 1'b1, 1'b0);
        end
        check("t038_np", nodes_passed, DEPTH + 1);

        repeat (12) begin
            pq.delete();
            len = $urandom_range(1, DEPTH);
            for (int i = 0; i < len; i++)
                pq.push_back({1'(i == len - 1), 2'($urandom_range(0, 3))});
            run_path();
        end

        // nodes_passed saturation over a 260-command path
        push_cmd(3'b000, acc);
        step();
        step();
        for (int i = 1; i <= 259; i++) node_step(1'b1, {1'(i == 259), 2'b00}, 1'b1, 1'b0);
        step();
        node_step(1'b0, 3'b000, 1'b1, 1'b0);
        check("sat_np", nodes_passed, 255);

        // node with empty queue, then node ignored while turning
        push_cmd(3'b000, acc);
        step();
        step();
        node_step(1'b0, 3'b000, 1'b1, 1'b0);
        node_step(1'b0, 3'b000, 1'b1, 1'b0);
        push_cmd(3'b101, acc);
        step();
        node_step(1'b0, 3'b000, 1'b1, 1'b1);
        check("t039_err", err, 1);

        // reset in the middle of a turn
        push_cmd(3'b111, acc);
        step();
        step();
        node_step(1'b0, 3'b000, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check_rst("rst_mid");
        step();
        check_rst("rst_hold");
        reset = 1'b0;
        model_reset();
        check("rdy_rel", cmd_if.cmd_ready, 0);
        step();
        check("rdy_rel_clk", cmd_if.cmd_ready, 1);
        pq.delete(); pq.push_back(3'b001); pq.push_back(3'b100);
        run_path();
        check("t040_hdg", heading, 2'b11);

        // turn that never completes
        push_cmd(3'b110, acc);
        push_cmd(3'b000, acc);
        push_cmd(3'b100, acc);
        step();
        step();
        node_step(1'b0, 3'b000, 1'b0, 1'b0);
`ifdef PATH_FOLLOWER_WATCHDOG_EN
        repeat (TMO - 1) step();
        check("wd_err_pre", err, 0);
        check("wd_busy_pre", busy, 1);
        step();
        check("wd_err", err, 1);
        check("wd_busy", busy, 0);
        check("wd_pd", path_done, 0);
        mq.delete();
        in_path = 1'b0;
        err_exp = 1'b1;
        repeat (3) step();
        check("wd_flushed", busy, 0);
        check("wd_rdy", cmd_if.cmd_ready, 1);
`else
        repeat (2 * TMO) step();
        check("nowd_err", err, 0);
        check("nowd_busy", busy, 1);
        turn_done = 1'b1;
        step();
        turn_done = 1'b0;
        check("nowd_pd", path_done, 1);
        n_pd_exp++;
        in_path = 1'b0;
        step();
        step();
        node_step(1'b0, 3'b000, 1'b1, 1'b0);
        node_step(1'b0, 3'b000, 1'b1, 1'b0);
`endif
        step();
        check("go_count", n_go_seen, n_go_exp);
        check("pd_count", n_pd_seen, n_pd_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/path_follower.md
PATH_FOLLOWER -- requirements
Module: path_follower

Interface
REQ-001 SHALL have parameter DEPTH, default 16: command FIFO depth in entries, power of two, minimum 2.
REQ-002 SHALL have parameter TIMEOUT, default 50_000_000: watchdog limit in clk_50 cycles, used only with the Configuration macro.
REQ-003 SHALL have port clk_50, input, 1 bit: single clock, all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit: planner offers a command.
REQ-006 SHALL have port cmd_data, input, 2 bits: command code, 00 straight, 01 left, 10 right, 11 backward.
REQ-007 SHALL have port cmd_last, input, 1 bit: marks the final command of a path.
REQ-008 SHALL have port cmd_ready, output, 1 bit: high when the FIFO is not full.
REQ-009 SHALL have port node_detect, input, 1 bit: one-cycle pulse from the line sensor each time a node is reached.
REQ-010 SHALL have port turn_done, input, 1 bit: one-cycle pulse from the motor controller when a manoeuvre completes.
REQ-011 SHALL have port motor_cmd, output, 2 bits: command being issued, same coding as cmd_data.
REQ-012 SHALL have port motor_go, output, 1 bit: one-cycle strobe that qualifies motor_cmd.
REQ-013 SHALL have port heading, output, 2 bits: current heading, 00 west, 01 east, 10 north, 11 south.
REQ-014 SHALL have port nodes_passed, output, 8 bits: count of commands issued in the current path.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-016 SHALL have port path_done, output, 1 bit: one-cycle pulse when the last command completes.
REQ-017 SHALL have port err, output, 1 bit: sticky error flag.

Function
REQ-018 SHALL accept a push when cmd_valid and cmd_ready are both high, storing {cmd_last, cmd_data}; a push with cmd_ready low SHALL be dropped and the FIFO left unchanged.
REQ-019 SHALL process a push and a pop in the same cycle correctly; occupancy is unchanged when that happens with the FIFO full.
REQ-020 SHALL implement FSM states IDLE, WAIT_NODE, ISSUE, TURNING, DONE; all outputs SHALL be registered.
REQ-021 SHALL move IDLE -> WAIT_NODE when the FIFO is non-empty, clearing nodes_passed on that transition.
REQ-022 In WAIT_NODE, SHALL pop the FIFO head and move to ISSUE when node_detect=1 and the FIFO is non-empty.
REQ-023 In WAIT_NODE, when node_detect=1 and the FIFO is empty, SHALL set err and remain in WAIT_NODE.
REQ-024 SHALL assert motor_go in the cycle after node_detect is sampled, with motor_cmd set to the popped code (latency 1).
REQ-025 In the ISSUE cycle, SHALL increment nodes_passed, saturating at 255.
REQ-026 In the ISSUE cycle, SHALL update heading: straight keeps it; left maps N->W, W->S, S->E, E->N; right maps N->E, E->S, S->W, W->N; backward maps W<->E and N<->S.
REQ-027 On leaving ISSUE, a straight command SHALL go to DONE if it was marked last, else to WAIT_NODE; any other command SHALL go to TURNING.
REQ-028 In TURNING, turn_done SHALL move the FSM to DONE if the command was marked last, else to WAIT_NODE.
REQ-029 SHALL pulse path_done for one cycle in DONE and then return to IDLE; heading and nodes_passed SHALL be held.
REQ-030 SHALL ignore node_detect outside WAIT_NODE and turn_done outside TURNING.
REQ-031 motor_cmd SHALL hold its last issued value between strobes.

Reset
REQ-032 While reset=1, regardless of clock, SHALL force: FSM to IDLE, FIFO emptied, cmd_ready=0, motor_cmd=00, motor_go=0, heading=00 (west), nodes_passed=0, busy=0, path_done=0, err=0.
REQ-033 A reset asserted mid-path SHALL abort the path with no further motor_go; cmd_ready SHALL return to 1 on the first clock after reset deasserts.

Configuration
REQ-034 With PATH_FOLLOWER_WATCHDOG_EN defined, SHALL count cycles spent in TURNING; when the count reaches TIMEOUT without turn_done, SHALL set err, flush the FIFO and go to IDLE without pulsing path_done.
REQ-035 With PATH_FOLLOWER_WATCHDOG_EN undefined, SHALL contain no watchdog counter, TURNING SHALL wait indefinitely, and err SHALL be set only by REQ-023.

Verification
REQ-036 Push {01,10,00(last)}, then give 3 node_detect pulses with turn_done after each turn -> motor_cmd sequence 01,10,00; heading W->S->W->W; nodes_passed=3; one path_done.
REQ-037 Push 11(last), node_detect, turn_done -> heading 00 -> 01; motor_go exactly 1 cycle after node_detect.
REQ-038 Push DEPTH+1 commands back-to-back -> cmd_ready low after DEPTH accepts, extra push dropped; simultaneous push/pop while full keeps occupancy at DEPTH.
REQ-039 node_detect with the FIFO empty in WAIT_NODE -> err=1, no motor_go; node_detect while in TURNING -> ignored.
REQ-040 Assert reset while in TURNING -> all outputs return to reset values immediately; a fresh path afterwards runs normally.
REQ-041 With the macro defined and TIMEOUT=20, hold turn_done=0 -> err=1 after 20 cycles, FSM in IDLE, FIFO empty, no path_done.
